token_window_counter: RTL and testbench

- Downstream stage of the token halver: consumes a serial one-bit token stream, one token per cycle where a=1.
- Counts tokens over fixed, back-to-back windows of WINDOW cycles.
- Emits one count per window on a valid/ready output, through a small FIFO.
- Flags and counts windows it had to drop because the consumer stalled.

---
 rtl/token_window_counter_pkg.sv | 12 +
 rtl/token_window_counter_if.sv | 13 +
 rtl/token_window_counter_fifo.sv | 68 ++++++
 rtl/token_window_counter.sv | 91 +++++++++
 tb/tb_token_window_counter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/token_window_counter_pkg.sv
// Shared constants for the token window counter: drop-counter sizing and window legality.
package token_pkg;

   localparam int unsigned DROP_CNT_W = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;
   localparam int unsigned MIN_WINDOW = 2;

   function automatic bit window_legal(input int unsigned window);
      return window >= MIN_WINDOW;
   endfunction

endpackage

// File: rtl/token_window_counter_if.sv
// Valid/ready result channel carrying one window count per transfer.
interface token_window_counter_if #(
   parameter int unsigned CNT_W = 4
) ();

   logic             valid;
   logic             ready;
   logic [CNT_W-1:0] count;

   modport master (output valid, output count, input ready);
   modport slave  (input valid, input count, output ready);

endinterface

// File: rtl/token_window_counter_fifo.sv
// Small result FIFO; occupancy counter separates full from empty, push+pop allowed when full.
module token_count_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("token_count_fifo: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (occ_q == OCC_W'(DEPTH));
   assign empty   = (occ_q == '0);
   assign head    = empty ? '0 : mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: rtl/token_window_counter.sv
// Counts tokens over back-to-back WINDOW-cycle windows and queues one count per window.
module token_window_counter
   import token_pkg::*;
#(
   parameter int unsigned WINDOW = 8,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   a,
   token_window_counter_if.master out_if,
   output logic                   overflow,
   output logic [DROP_CNT_W-1:0]  drop_cnt
);

   localparam int unsigned CNT_W = $clog2(WINDOW + 1);
   localparam int unsigned CYC_W = $clog2(WINDOW);

   if (!window_legal(WINDOW)) begin : g_bad_window
      $error("token_window_counter: WINDOW must be >= 2");
   end

   logic [CYC_W-1:0]      cyc_q, cyc_d;
   logic [CNT_W-1:0]      acc_q, acc_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             last;
   logic [CNT_W-1:0] sum;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_head;
   logic             pop;
   logic             push;
   logic             drop;

   assign last = (cyc_q == CYC_W'(WINDOW - 1));
   assign sum  = acc_q + CNT_W'(a);
   assign pop  = !fifo_empty && out_if.ready;
   // A full FIFO still takes the result when the head leaves in the same cycle.
   assign push = last && (!fifo_full || pop);
   assign drop = last && fifo_full && !pop;

   always_comb begin
      cyc_d      = cyc_q + CYC_W'(1);
      acc_d      = sum;
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (last) begin
         cyc_d = '0;
         acc_d = '0;
      end
      if (drop && (drop_cnt_q != DROP_CNT_MAX)) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q      <= '0;
         acc_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         cyc_q      <= cyc_d;
         acc_q      <= acc_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   token_count_fifo #(
      .WIDTH (CNT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (sum),
      .full      (fifo_full),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty)
   );

   assign out_if.valid = !fifo_empty;
   assign out_if.count = fifo_head;
   assign overflow     = overflow_q;
   assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_token_window_counter.sv
// Bench for token_window_counter: queue-based window model checked every cycle plus pinned scenarios.
module tb_token_window_counter;

   localparam int unsigned WINDOW = 4;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned CNT_W  = $clog2(WINDOW + 1);

   logic       clk;
   logic       rst;
   logic       a;
   logic       overflow;
   logic [7:0] drop_cnt;

   token_window_counter_if #(.CNT_W(CNT_W)) bus ();

   token_window_counter #(
      .WINDOW (WINDOW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .out_if   (bus),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: a queue of finished window counts plus the running window tally.
   int q[$];
   int m_pos  = 0;
   int m_acc  = 0;
   int m_drop = 0;
   bit m_ovf  = 1'b0;
   bit m_init = 1'b0;

   always @(posedge clk) begin : model
      int  sz;
      bit  popped;
      if (rst) begin
         q.delete();
         m_pos  = 0;
         m_acc  = 0;
         m_drop = 0;
         m_ovf  = 1'b0;
         m_init = 1'b1;
      end else begin
         sz     = q.size();
         popped = (sz > 0) && bus.ready;
         if (popped) void'(q.pop_front());
         m_acc += int'(a);
         if (m_pos == int'(WINDOW) - 1) begin
            if (sz < int'(DEPTH) || popped) q.push_back(m_acc);
            else begin
               if (m_drop < 255) m_drop++;
               m_ovf = 1'b1;
            end
            m_acc = 0;
            m_pos = 0;
         end else begin
            m_pos++;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("out_valid", int'(bus.valid), int'(q.size() > 0));
         chk("out_count", int'(bus.count), (q.size() > 0) ? q[0] : 0);
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("drop_cnt", int'(drop_cnt), m_drop);
      end
   end

   task automatic cyc(input logic av, input logic rdy, input logic r = 1'b0);
      @(negedge clk);
      a         = av;
      bus.ready = rdy;
      rst       = r;
   endtask

   task automatic win(input logic [3:0] bits, input logic rdy);
      for (int i = 0; i < 4; i++) cyc(bits[i], rdy);
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      a         = 1'b0;
      bus.ready = 1'b0;
      rst       = 1'b1;

      // Basic count: 1,1,0,1 -> 3, gone one cycle later
      do_reset();
      win(4'b1011, 1'b1);
      cyc(1'b0, 1'b1);
      chk("basic_valid", int'(bus.valid), 1);
      chk("basic_count", int'(bus.count), 3);
      cyc(1'b0, 1'b1);
      chk("basic_popped", int'(bus.valid), 0);

      // Last-cycle token, all ones, all zeros
      do_reset();
      win(4'b1000, 1'b1);
      cyc(1'b1, 1'b1);
      chk("last_tok_count", int'(bus.count), 1);
      cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      chk("all_ones_count", int'(bus.count), 4);
      cyc(1'b0, 1'b1); cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      chk("zero_win_valid", int'(bus.valid), 1);
      chk("zero_win_count", int'(bus.count), 0);

      // Backpressure without loss
      do_reset();
      win(4'b0011, 1'b0);
      win(4'b0111, 1'b0);
      cyc(1'b0, 1'b0);
      chk("bp_hold_count", int'(bus.count), 2);
      cyc(1'b0, 1'b1);
      chk("bp_first", int'(bus.count), 2);
      cyc(1'b0, 1'b1);
      chk("bp_second", int'(bus.count), 3);
      cyc(1'b0, 1'b1);
      chk("bp_empty", int'(bus.valid), 0);
      chk("bp_no_ovf", int'(overflow), 0);

      // Drop: counts 1,2,4 with consumer stalled
      do_reset();
      win(4'b0001, 1'b0);
      win(4'b0011, 1'b0);
      win(4'b1111, 1'b0);
      cyc(1'b0, 1'b0);
      chk("drop_cnt_1", int'(drop_cnt), 1);
      chk("drop_ovf", int'(overflow), 1);
      cyc(1'b0, 1'b1);
      chk("drain_1", int'(bus.count), 1);
      cyc(1'b0, 1'b1);
      chk("drain_2", int'(bus.count), 2);
      cyc(1'b0, 1'b1);
      chk("drain_empty", int'(bus.valid), 0);

      // Reset mid-window clears sticky state and the partial window
      cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      cyc(1'b0, 1'b1); cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      chk("rst_no_carry", int'(bus.count), 1);

      // Full FIFO, ready only on the push cycle: no drop
      do_reset();
      win(4'b0001, 1'b0);
      win(4'b0001, 1'b0);
      cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      chk("full_pushpop_drop", int'(drop_cnt), 0);
      chk("full_pushpop_head", int'(bus.count), 1);

      // Saturation: 260 stalled windows
      do_reset();
      for (int w = 0; w < 260; w++) win(4'($urandom_range(0, 15)), 1'b0);
      cyc(1'b0, 1'b0);
      chk("sat_drop", int'(drop_cnt), 255);
      chk("sat_ovf", int'(overflow), 1);

      // Randomized traffic with varying consumer duty and rare resets
      do_reset();
      for (int blk = 0; blk < 60; blk++) begin
         int duty;
         duty = int'($urandom_range(0, 4));
         for (int i = 0; i < 50; i++) begin
            cyc(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) < duty),
                1'($urandom_range(0, 299) == 0));
         end
      end
      cyc(1'b0, 1'b1);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
